// File: rtl/game_pkg.sv
// Shared constants for the game front end: channel map, idle levels and the
// edge-classification helper used by the debounce channels.
package game_pkg;

  localparam int CH_COUNT = 4;

  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_JUMP  = 2;
  localparam int CH_START = 3;

  localparam logic [3:0] IDLE_MASK_DEFAULT = 4'b1100;

  // True when a level moves off the reference value (press if ref is idle).
  function automatic logic leaves_level(input logic ref_level, input logic cur_level,
                                        input logic nxt_level);
    return (cur_level == ref_level) && (nxt_level != ref_level);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Board-input / conditioned-output bundle between the input conditioner and
// the game logic that consumes it.
interface input_conditioner_if;
  import game_pkg::*;

  logic [CH_COUNT-1:0] raw_in;
  logic [CH_COUNT-1:0] level_out;
  logic [CH_COUNT-1:0] press_pulse;
  logic [CH_COUNT-1:0] release_pulse;
  logic                dir_conflict;

  modport master (
    output raw_in,
    input  level_out, press_pulse, release_pulse, dir_conflict
  );

  modport slave (
    input  raw_in,
    output level_out, press_pulse, release_pulse, dir_conflict
  );

endinterface

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchronizer, run-length debounce counter and a
// registered press/release pulse pair.
module debounce_channel
  import game_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_next_level,
  output logic o_press,
  output logic o_release
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic             r_release;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_stable_next;

  // Count consecutive samples that disagree with the accepted level; accept at terminal count.
  always_comb begin
    w_cnt_next    = '0;
    w_stable_next = r_stable;
    if (r_sync2 == r_stable) begin
      w_cnt_next = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_stable_next = r_sync2;
      w_cnt_next    = '0;
    end else begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // Synchronizer, debounce state and edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= IDLE_LEVEL;
      r_sync2   <= IDLE_LEVEL;
      r_stable  <= IDLE_LEVEL;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_stable  <= w_stable_next;
      r_cnt     <= w_cnt_next;
      r_press   <= leaves_level(IDLE_LEVEL, r_stable, w_stable_next);
      r_release <= leaves_level(~IDLE_LEVEL, r_stable, w_stable_next);
    end
  end

  assign o_level      = r_stable;
  assign o_next_level = w_stable_next;
  assign o_press      = r_press;
  assign o_release    = r_release;

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: one debounce channel per key/switch plus the
// left/right conflict flag, all in the vga_clock domain.
module input_conditioner
  import game_pkg::*;
#(
  parameter int                DEBOUNCE_CYCLES = 250000,
  parameter int                NUM_CH          = 4,
  parameter logic [NUM_CH-1:0] IDLE_MASK       = IDLE_MASK_DEFAULT
) (
  input  logic                vga_clock,
  input  logic                reset,
  input_conditioner_if.slave  bus
);

  logic [NUM_CH-1:0] w_level;
  logic [NUM_CH-1:0] w_next_level;
  logic [NUM_CH-1:0] w_press;
  logic [NUM_CH-1:0] w_release;
  logic              r_dir_conflict;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_MASK[g])
    ) u_ch (
      .clk          (vga_clock),
      .rst          (reset),
      .i_raw        (bus.raw_in[g]),
      .o_level      (w_level[g]),
      .o_next_level (w_next_level[g]),
      .o_press      (w_press[g]),
      .o_release    (w_release[g])
    );
  end

  // Conflict tracks the accepted levels so it moves on the same edge as level_out.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      r_dir_conflict <= 1'b0;
    end else begin
      r_dir_conflict <= w_next_level[CH_LEFT] & w_next_level[CH_RIGHT];
    end
  end

  assign bus.level_out     = w_level;
  assign bus.press_pulse   = w_press;
  assign bus.release_pulse = w_release;
  assign bus.dir_conflict  = r_dir_conflict;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized checks of input_conditioner against a window-based
// reference: a level flips once the last DEBOUNCE_CYCLES synced samples all disagree with it.
module tb_input_conditioner;
  import game_pkg::*;

  localparam int         DC   = 4;
  localparam logic [3:0] IDLE = 4'b1100;

  logic vga_clock = 1'b0;
  logic reset     = 1'b1;

  input_conditioner_if bus();

  input_conditioner #(
    .DEBOUNCE_CYCLES (DC),
    .NUM_CH          (4),
    .IDLE_MASK       (IDLE)
  ) dut (
    .vga_clock (vga_clock),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 vga_clock = ~vga_clock;

  int total = 0;
  int bad   = 0;

  logic [3:0] pipe_q[$];
  logic [3:0] win_q[$];
  logic [3:0] m_level;
  logic [3:0] m_press;
  logic [3:0] m_rel;
  int         trans_cnt[4];
  int         pulse_cnt[4];
  logic       seen_press0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe_q = '{IDLE, IDLE};
    win_q.delete();
    for (int i = 0; i < DC; i++) win_q.push_back(IDLE);
    m_level = IDLE;
    m_press = 4'b0000;
    m_rel   = 4'b0000;
  endtask

  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] seen;
    logic [3:0] all1;
    logic [3:0] all0;
    logic [3:0] nxt;
    seen = pipe_q.pop_front();
    pipe_q.push_back(raw);
    void'(win_q.pop_front());
    win_q.push_back(seen);
    all1 = 4'b1111;
    all0 = 4'b1111;
    foreach (win_q[k]) begin
      all1 &= win_q[k];
      all0 &= ~win_q[k];
    end
    nxt = m_level;
    for (int c = 0; c < 4; c++) begin
      if (all1[c]) nxt[c] = 1'b1;
      else if (all0[c]) nxt[c] = 1'b0;
      if (nxt[c] != m_level[c]) trans_cnt[c]++;
    end
    m_press = (nxt ^ m_level) & (nxt ^ IDLE);
    m_rel   = (nxt ^ m_level) & ~(nxt ^ IDLE);
    m_level = nxt;
  endtask

  task automatic tick(input logic [3:0] raw);
    bus.raw_in = raw;
    @(posedge vga_clock);
    model_edge(raw);
    #1;
    chk("level", bus.level_out, m_level);
    chk("press", bus.press_pulse, m_press);
    chk("release", bus.release_pulse, m_rel);
    chk("conflict", bus.dir_conflict, m_level[0] & m_level[1]);
    chk("overlap", bus.press_pulse & bus.release_pulse, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      if (bus.press_pulse[c] | bus.release_pulse[c]) pulse_cnt[c]++;
    end
  endtask

  initial begin
    bus.raw_in = IDLE;
    model_reset();
    repeat (2) @(posedge vga_clock);
    #1;
    chk("rst_level", bus.level_out, IDLE);
    chk("rst_press", bus.press_pulse, 4'b0000);
    chk("rst_release", bus.release_pulse, 4'b0000);
    chk("rst_conflict", bus.dir_conflict, 1'b0);
    reset = 1'b0;

    repeat (20) tick(IDLE);

    // Jump key press: edge N loads sync1, level/pulse change after edge N+5.
    tick(4'b1000);
    for (int k = 1; k <= 5; k++) begin
      tick(4'b1000);
      if (k < 5) begin
        chk("jump_early_level", bus.level_out[2], 1'b1);
        chk("jump_early_press", bus.press_pulse, 4'b0000);
      end else begin
        chk("jump_level", bus.level_out[2], 1'b0);
        chk("jump_press", bus.press_pulse, 4'b0100);
        chk("jump_norel", bus.release_pulse, 4'b0000);
      end
    end
    tick(4'b1000);
    chk("jump_press_once", bus.press_pulse, 4'b0000);
    repeat (8) tick(IDLE);

    // Three-cycle glitch on left must be swallowed.
    seen_press0 = 1'b0;
    repeat (3) begin
      tick(4'b1101);
      seen_press0 |= bus.press_pulse[0];
    end
    repeat (8) begin
      tick(IDLE);
      seen_press0 |= bus.press_pulse[0];
      chk("glitch_level", bus.level_out[0], 1'b0);
    end
    chk("glitch_nopress", seen_press0, 1'b0);

    // Four cycles high is accepted; the fall releases 5 edges after reaching sync1.
    repeat (4) tick(4'b1101);
    tick(IDLE);
    for (int k = 1; k <= 5; k++) begin
      tick(IDLE);
      if (k == 1) begin
        chk("pulse4_level", bus.level_out[0], 1'b1);
        chk("pulse4_press", bus.press_pulse, 4'b0001);
      end
      if (k == 5) begin
        chk("pulse4_release", bus.release_pulse, 4'b0001);
        chk("pulse4_fall", bus.level_out[0], 1'b0);
      end
    end
    repeat (4) tick(IDLE);

    // Left and right together: joint press and conflict, then right release clears it.
    tick(4'b1111);
    for (int k = 1; k <= 5; k++) begin
      tick(4'b1111);
      if (k == 4) chk("both_noconf_yet", bus.dir_conflict, 1'b0);
      if (k == 5) begin
        chk("both_press", bus.press_pulse, 4'b0011);
        chk("both_level", bus.level_out[1:0], 2'b11);
        chk("both_conf", bus.dir_conflict, 1'b1);
      end
    end
    tick(4'b1101);
    for (int k = 1; k <= 5; k++) begin
      tick(4'b1101);
      if (k == 4) chk("drop_conf_held", bus.dir_conflict, 1'b1);
      if (k == 5) begin
        chk("drop_release", bus.release_pulse, 4'b0010);
        chk("drop_conf", bus.dir_conflict, 1'b0);
      end
    end
    repeat (8) tick(IDLE);

    // Reset two cycles into a start-key debounce while left is held active.
    repeat (8) tick(4'b1101);
    chk("pre_rst_level", bus.level_out, 4'b1101);
    repeat (3) tick(4'b0101);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_level", bus.level_out, IDLE);
    chk("async_press", bus.press_pulse, 4'b0000);
    chk("async_release", bus.release_pulse, 4'b0000);
    chk("async_conf", bus.dir_conflict, 1'b0);
    repeat (2) @(posedge vga_clock);
    #1;
    chk("held_level", bus.level_out, IDLE);
    reset = 1'b0;
    tick(4'b0101);
    for (int k = 1; k <= 5; k++) begin
      tick(4'b0101);
      if (k < 5) chk("restart_early", bus.press_pulse[3], 1'b0);
      else chk("restart_press", bus.press_pulse, 4'b1001);
    end
    repeat (8) tick(IDLE);

    // Random bounce stress: each bit toggles with probability 1/8 per cycle.
    for (int c = 0; c < 4; c++) begin
      trans_cnt[c] = 0;
      pulse_cnt[c] = 0;
    end
    begin
      logic [3:0] raw;
      raw = IDLE;
      for (int n = 0; n < 10000; n++) begin
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(0, 7) == 0) raw[c] = ~raw[c];
        end
        tick(raw);
      end
    end
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("pulse_count_ch%0d", c), pulse_cnt[c], trans_cnt[c]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
